// File: rtl/spi_receiver.sv
// SPI slave receiver: synchronizes the serial pins into the i_clk domain,
// assembles bytes on serial-clock rising edges, and presents them through a
// valid/ready holding register with overrun and abort reporting.
module spi_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter bit MSB_FIRST   = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_s_clk,
  input  logic       i_mosi,
  input  logic       i_ss,
  input  logic       i_ready,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_overrun,
  output logic       o_abort,
  output logic       o_busy
);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, ss_sync;
  logic                   sclk_d;
  logic                   sclk_s, mosi_s, ss_s;
  logic                   take;

  state_t     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic [7:0] sh, sh_nxt, sh_cap;
  logic       done, abort_nxt;

  // Synchronizer chains; s_clk and ss reset to their idle-high level so no
  // phantom edge or select is seen when reset releases.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sclk_sync <= '1;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_s_clk};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], i_ss};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_mosi};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];

  // Only rising serial edges with slave select low carry data.
  assign take   = sclk_s & ~sclk_d & ~ss_s;
  assign sh_cap = MSB_FIRST ? {sh[6:0], mosi_s} : {mosi_s, sh[7:1]};

  // Bit-assembly state, counter and shift register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      cnt   <= '0;
      sh    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sh    <= sh_nxt;
    end
  end

  // Next-state: ss deassertion beats a coincident edge; the 8th bit wraps
  // the counter to 0 and returns to IDLE so the next byte can follow at once.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sh_nxt    = sh;
    done      = 1'b0;
    abort_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (take) begin
          sh_nxt    = sh_cap;
          cnt_nxt   = 3'd1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (ss_s) begin
          abort_nxt = 1'b1;
          cnt_nxt   = '0;
          sh_nxt    = '0;
          state_nxt = IDLE;
        end else if (take) begin
          sh_nxt  = sh_cap;
          cnt_nxt = cnt + 3'd1;
          if (cnt == 3'd7) begin
            done      = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output holding register: a completed byte loads if the slot is empty or
  // being consumed this cycle, otherwise it is dropped and flagged.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_data    <= '0;
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;
      o_abort   <= 1'b0;
    end else begin
      o_overrun <= 1'b0;
      o_abort   <= abort_nxt;
      if (done) begin
        if (!o_valid || i_ready) begin
          o_data  <= sh_cap;
          o_valid <= 1'b1;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

  assign o_busy = (state == SHIFT);

endmodule

// File: tb/tb_spi_receiver.sv
// Bench for spi_receiver: an MSB-first and an LSB-first instance share the
// serial pins; a monitor logs consumed bytes and pulses, and each scenario
// task compares against expectations computed from the sent bytes.
module tb_spi_receiver;

  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst, sclk, mosi, ss, ready;
  logic [7:0] data_m, data_l;
  logic valid_m, valid_l, ovrp_m, ovrp_l, abtp_m, abtp_l, busy_m, busy_l;

  int checks = 0;
  int errors = 0;

  logic [7:0] acc_m[$];
  logic [7:0] acc_l[$];
  int ovr_m, ovr_l, abt_m, abt_l;

  always #5 clk = ~clk;

  spi_receiver #(.SYNC_STAGES(SYNC), .MSB_FIRST(1)) u_msb (
    .i_clk(clk), .i_rst(rst), .i_s_clk(sclk), .i_mosi(mosi), .i_ss(ss),
    .i_ready(ready), .o_data(data_m), .o_valid(valid_m),
    .o_overrun(ovrp_m), .o_abort(abtp_m), .o_busy(busy_m));

  spi_receiver #(.SYNC_STAGES(SYNC), .MSB_FIRST(0)) u_lsb (
    .i_clk(clk), .i_rst(rst), .i_s_clk(sclk), .i_mosi(mosi), .i_ss(ss),
    .i_ready(ready), .o_data(data_l), .o_valid(valid_l),
    .o_overrun(ovrp_l), .o_abort(abtp_l), .o_busy(busy_l));

  // Log handshakes and pulses mid-cycle, where inputs and outputs are settled.
  always @(negedge clk) begin
    #1;
    if (valid_m && ready) acc_m.push_back(data_m);
    if (valid_l && ready) acc_l.push_back(data_l);
    if (ovrp_m) ovr_m++;
    if (ovrp_l) ovr_l++;
    if (abtp_m) abt_m++;
    if (abtp_l) abt_l++;
  end

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  task automatic clear_log();
    acc_m.delete(); acc_l.delete();
    ovr_m = 0; ovr_l = 0; abt_m = 0; abt_l = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One serial bit: data changes with the falling edge, sampled on the rise.
  task automatic send_bit(input logic b, input int lo, input int hi);
    @(negedge clk);
    mosi = b; sclk = 1'b0;
    repeat (lo) @(negedge clk);
    sclk = 1'b1;
    repeat (hi - 1) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] v, input int lo, input int hi);
    for (int i = 7; i >= 0; i--) send_bit(v[i], lo, hi);
  endtask

  task automatic test_reset();
    rst = 1'b1; sclk = 1'b1; mosi = 1'b0; ss = 1'b1; ready = 1'b0;
    idle(3);
    checks++;
    if ({data_m, valid_m, ovrp_m, abtp_m, busy_m} !== 12'h000) begin
      errors++;
      $display("FAIL reset_msb got %h exp 000", {data_m, valid_m, ovrp_m, abtp_m, busy_m});
    end
    checks++;
    if ({data_l, valid_l, ovrp_l, abtp_l, busy_l} !== 12'h000) begin
      errors++;
      $display("FAIL reset_lsb got %h exp 000", {data_l, valid_l, ovrp_l, abtp_l, busy_l});
    end
    rst = 1'b0;
    idle(2);
    clear_log();
  endtask

  task automatic test_basic();
    logic [7:0] v = 8'hA5;
    int lat;
    ss = 1'b0; ready = 1'b0;
    idle(4);
    clear_log();
    for (int i = 7; i >= 1; i--) send_bit(v[i], 4, 4);
    checks++;
    if (busy_m !== 1'b1) begin
      errors++; $display("FAIL basic_busy got %b exp 1", busy_m);
    end
    @(negedge clk); mosi = v[0]; sclk = 1'b0;
    repeat (4) @(negedge clk);
    sclk = 1'b1;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk); lat++;
      if (valid_m) break;
    end
    checks++;
    if (lat !== SYNC + 1) begin
      errors++; $display("FAIL basic_latency got %0d exp %0d", lat, SYNC + 1);
    end
    idle(10);
    checks++;
    if ({valid_m, data_m} !== {1'b1, v}) begin
      errors++; $display("FAIL basic_hold got %b/%h exp 1/%h", valid_m, data_m, v);
    end
    checks++;
    if (data_l !== rev8(v)) begin
      errors++; $display("FAIL basic_lsb got %h exp %h", data_l, rev8(v));
    end
    ready = 1'b1;
    @(negedge clk); ready = 1'b0;
    checks++;
    if (valid_m !== 1'b0) begin
      errors++; $display("FAIL basic_clear got %b exp 0", valid_m);
    end
    idle(2);
    checks++;
    if (acc_m.size() != 1 || acc_m[0] !== v) begin
      errors++; $display("FAIL basic_accept got n=%0d exp one %h", acc_m.size(), v);
    end
  endtask

  task automatic test_lsb_first();
    clear_log();
    ready = 1'b1;
    send_byte(8'h80, 3, 3);
    idle(8);
    checks++;
    if (acc_l.size() != 1 || acc_l[0] !== 8'h01) begin
      errors++; $display("FAIL lsb_first got n=%0d exp one 01", acc_l.size());
    end
  endtask

  task automatic test_back_to_back();
    clear_log();
    ready = 1'b1; ss = 1'b0;
    send_byte(8'h3C, 2, 2);
    send_byte(8'hC3, 2, 2);
    idle(8);
    checks++;
    if (acc_m.size() != 2 || acc_m[0] !== 8'h3C || acc_m[1] !== 8'hC3) begin
      errors++; $display("FAIL b2b_msb got n=%0d exp 3c,c3", acc_m.size());
    end
    checks++;
    if (acc_l.size() != 2 || acc_l[0] !== rev8(8'h3C) || acc_l[1] !== rev8(8'hC3)) begin
      errors++; $display("FAIL b2b_lsb got n=%0d exp 3c,c3 reversed", acc_l.size());
    end
    checks++;
    if (ovr_m + ovr_l != 0) begin
      errors++; $display("FAIL b2b_overrun got %0d exp 0", ovr_m + ovr_l);
    end
  endtask

  task automatic test_overrun();
    clear_log();
    ready = 1'b0;
    send_byte(8'h11, 3, 3);
    send_byte(8'h22, 3, 3);
    idle(8);
    checks++;
    if ({valid_m, data_m} !== {1'b1, 8'h11}) begin
      errors++; $display("FAIL ovr_data got %b/%h exp 1/11", valid_m, data_m);
    end
    checks++;
    if (ovr_m != 1 || ovr_l != 1) begin
      errors++; $display("FAIL ovr_pulse got %0d/%0d exp 1/1", ovr_m, ovr_l);
    end
    ready = 1'b1;
    @(negedge clk); ready = 1'b0;
    idle(2);
    checks++;
    if (acc_m.size() != 1 || acc_m[0] !== 8'h11) begin
      errors++; $display("FAIL ovr_drain got n=%0d exp one 11", acc_m.size());
    end
  endtask

  // Accept the held byte in exactly the cycle the next byte completes.
  task automatic test_accept_collision();
    logic [7:0] b1 = 8'($urandom);
    logic [7:0] b2 = 8'($urandom);
    clear_log();
    ready = 1'b0;
    send_byte(b1, 3, 3);
    idle(6);
    for (int i = 7; i >= 1; i--) send_bit(b2[i], 3, 3);
    @(negedge clk); mosi = b2[0]; sclk = 1'b0;
    repeat (3) @(negedge clk);
    sclk = 1'b1;
    repeat (SYNC) @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({valid_m, data_m, data_l} !== {1'b1, b2, rev8(b2)}) begin
      errors++; $display("FAIL collide_load got %b/%h/%h exp 1/%h/%h",
                         valid_m, data_m, data_l, b2, rev8(b2));
    end
    ready = 1'b0;
    idle(4);
    checks++;
    if (ovr_m != 0 || acc_m.size() != 1 || acc_m[0] !== b1) begin
      errors++; $display("FAIL collide_accept got ovr=%0d n=%0d exp ovr=0 one %h",
                         ovr_m, acc_m.size(), b1);
    end
    ready = 1'b1;
    idle(2);
  endtask

  task automatic test_abort();
    clear_log();
    ready = 1'b1;
    for (int i = 0; i < 5; i++) send_bit(1'b1, 3, 3);
    checks++;
    if (busy_m !== 1'b1) begin
      errors++; $display("FAIL abort_busy got %b exp 1", busy_m);
    end
    @(negedge clk); ss = 1'b1;
    idle(6);
    checks++;
    if (abt_m != 1 || abt_l != 1 || busy_m !== 1'b0 || acc_m.size() != 0) begin
      errors++; $display("FAIL abort_pulse got abt=%0d/%0d busy=%b n=%0d exp 1/1 0 0",
                         abt_m, abt_l, busy_m, acc_m.size());
    end
    @(negedge clk); ss = 1'b0;
    idle(3);
    send_byte(8'h81, 3, 3);
    idle(8);
    checks++;
    if (acc_m.size() != 1 || acc_m[0] !== 8'h81 || abt_m != 1) begin
      errors++; $display("FAIL abort_next got n=%0d abt=%0d exp one 81 abt=1",
                         acc_m.size(), abt_m);
    end
  endtask

  task automatic test_reset_mid();
    clear_log();
    ready = 1'b1;
    for (int i = 0; i < 3; i++) send_bit(i[0], 3, 3);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({data_m, valid_m, ovrp_m, abtp_m, busy_m} !== 12'h000) begin
      errors++; $display("FAIL rstmid_outputs got %h exp 000",
                         {data_m, valid_m, ovrp_m, abtp_m, busy_m});
    end
    rst = 1'b0;
    idle(4);
    send_byte(8'h5A, 3, 3);
    idle(8);
    checks++;
    if (abt_m != 0 || acc_m.size() != 1 || acc_m[0] !== 8'h5A) begin
      errors++; $display("FAIL rstmid_next got abt=%0d n=%0d exp abt=0 one 5a",
                         abt_m, acc_m.size());
    end
  endtask

  // Random bytes, random phase lengths, random ss gaps and mid-byte aborts.
  task automatic test_random();
    logic [7:0] exp_q[$];
    int exp_abort = 0;
    logic [7:0] v;
    clear_log();
    ready = 1'b1;
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        int k = $urandom_range(1, 7);
        for (int i = 0; i < k; i++) send_bit(1'($urandom), 2, 2);
        @(negedge clk); ss = 1'b1;
        idle(4);
        ss = 1'b0;
        idle(3);
        exp_abort++;
      end else begin
        v = 8'($urandom);
        send_byte(v, $urandom_range(2, 5), $urandom_range(2, 5));
        exp_q.push_back(v);
        if ($urandom_range(0, 2) == 0) begin
          idle(4); ss = 1'b1; idle(3); ss = 1'b0; idle(3);
        end
      end
    end
    idle(8);
    checks++;
    if (acc_m.size() != exp_q.size() || acc_l.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_count got %0d/%0d exp %0d",
                         acc_m.size(), acc_l.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (acc_m[i] !== exp_q[i] || acc_l[i] !== rev8(exp_q[i])) begin
          errors++; $display("FAIL rand_byte%0d got %h/%h exp %h/%h",
                             i, acc_m[i], acc_l[i], exp_q[i], rev8(exp_q[i]));
        end
      end
    end
    checks++;
    if (abt_m != exp_abort || abt_l != exp_abort || ovr_m != 0) begin
      errors++; $display("FAIL rand_flags got abt=%0d/%0d ovr=%0d exp abt=%0d ovr=0",
                         abt_m, abt_l, ovr_m, exp_abort);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lsb_first();
    test_back_to_back();
    test_overrun();
    test_accept_collision();
    test_abort();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_receiver.md
SPI_RECEIVER -- requirements
Module: spi_receiver

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of flip-flop synchronizer stages on i_s_clk, i_mosi and i_ss (legal 2..3).
REQ-002 SHALL have parameter MSB_FIRST, default 1; 1 = first received bit lands in bit 7, 0 = first bit lands in bit 0.
REQ-003 SHALL have port i_clk, input, 1, system clock; all logic on its rising edge.
REQ-004 SHALL have port i_rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port i_s_clk, input, 1, asynchronous serial clock; idle high; data sampled on its rising edge.
REQ-006 SHALL have port i_mosi, input, 1, asynchronous serial data.
REQ-007 SHALL have port i_ss, input, 1, active-low asynchronous slave select; may be tied low.
REQ-008 SHALL have port i_ready, input, 1, consumer accepts o_data when high with o_valid.
REQ-009 SHALL have port o_data, output, 8, received byte.
REQ-010 SHALL have port o_valid, output, 1, o_data holds an unconsumed byte.
REQ-011 SHALL have port o_overrun, output, 1, one-cycle pulse: completed byte dropped.
REQ-012 SHALL have port o_abort, output, 1, one-cycle pulse: i_ss deasserted mid-byte.
REQ-013 SHALL have port o_busy, output, 1, high while a byte is partially received.

Function
REQ-014 SHALL pass i_s_clk, i_mosi and i_ss each through SYNC_STAGES flip-flops before use; i_s_clk synchronizers reset to 1, i_ss to 1, i_mosi to 0.
REQ-015 SHALL detect a serial rising edge when synchronized s_clk is 1 and its one-cycle-delayed copy is 0; no other edge type is used.
REQ-016 SHALL require i_s_clk high and low phases each at least 2 i_clk periods; behaviour outside this is undefined.
REQ-017 SHALL implement FSM states IDLE, SHIFT, HOLD-free: IDLE (synchronized ss high or no bits yet) and SHIFT (1..7 bits captured).
REQ-018 SHALL ignore detected edges while synchronized ss is high.
REQ-019 IDLE -> SHIFT on detected edge with ss low: capture synchronized mosi, bit counter = 1.
REQ-020 SHIFT: each detected edge captures one bit and increments the 3-bit counter; on the 8th bit the counter wraps to 0 and state returns to IDLE.
REQ-021 On the 8th-bit edge cycle, the full byte SHALL be written to o_data and o_valid set on the next i_clk edge (registered, 1-cycle latency from edge detection).
REQ-022 o_valid SHALL remain high and o_data stable until a cycle with o_valid and i_ready both high; o_valid clears on the following edge.
REQ-023 If a new byte completes in the same cycle as acceptance (o_valid & i_ready), the new byte SHALL load and o_valid stay high; no overrun.
REQ-024 If a byte completes while o_valid is high and i_ready low, the new byte SHALL be discarded, o_data unchanged, o_overrun pulsed one cycle.
REQ-025 If synchronized ss rises while in SHIFT, SHALL discard the partial byte, clear counter, go IDLE, pulse o_abort one cycle; o_valid/o_data unaffected.
REQ-026 If ss rises and an edge is detected in the same cycle, ss SHALL win: edge ignored, abort taken.
REQ-027 o_busy SHALL equal (state == SHIFT).
REQ-028 Back-to-back bytes with ss held low SHALL need no gap; bit 1 of the next byte may arrive on the edge after bit 8.

Reset
REQ-029 While i_rst is high on an i_clk edge: state IDLE, counter 0, shift register 0, o_data 0x00, o_valid 0, o_overrun 0, o_abort 0, o_busy 0, synchronizers to REQ-014 values.
REQ-030 Reset mid-byte SHALL discard partial bits without pulsing o_abort; first detected edge after reset release starts a new byte.

Verification
REQ-031 ss low, send 0xA5 MSB first at i_clk/8, i_ready low -> o_valid rises 1 cycle after 8th detected edge, o_data=0xA5, held until i_ready.
REQ-032 MSB_FIRST=0, send bit sequence 1,0,0,0,0,0,0,0 -> o_data=0x01.
REQ-033 ss tied low, i_ready high, send 0x3C then 0xC3 with no gap -> two o_valid pulses, data 0x3C then 0xC3, no o_overrun.
REQ-034 i_ready low, send 0x11 then 0x22 -> o_data stays 0x11, o_overrun pulses once after 0x22's 8th edge.
REQ-035 ss raised after 5 bits of 0xFF, then 0x81 sent -> o_abort pulse once, no o_valid for partial, next o_data=0x81.
REQ-036 i_rst asserted after 3 bits -> all outputs 0, no o_abort; following 0x5A received correctly.
